// File: rtl/nios_led_pwm_pio.sv
`default_nettype none
// ============================================================================
// Module   : nios_led_pwm_pio
// Purpose  : Avalon-MM LED/output PIO with atomic set/clear, per-channel
//            static or PWM brightness mode, programmable prescaler and
//            per-channel duty registers. Zero wait states, read latency 0.
// Revision : 1.0 - initial release
// ============================================================================
module nios_led_pwm_pio #(
  parameter int WIDTH       = 4,   // output channels (1..8)
  parameter int PWM_BITS    = 8,   // PWM counter/duty width (2..16)
  parameter int PRESC_BITS  = 16,  // prescaler counter width
  parameter int PRESC_RESET = 0    // prescaler reload value after reset
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [3:0] c_addr_data     = 4'd0;
  localparam logic [3:0] c_addr_outset   = 4'd1;
  localparam logic [3:0] c_addr_outclear = 4'd2;
  localparam logic [3:0] c_addr_mode     = 4'd3;
  localparam logic [3:0] c_addr_prescale = 4'd4;
  localparam logic [3:0] c_addr_pwmcnt   = 4'd5;
  localparam logic [3:0] c_addr_duty0    = 4'd8;

  logic                  wr_en;
  logic                  tick;
  logic [WIDTH-1:0]      data_q, data_d;
  logic [WIDTH-1:0]      mode_q, mode_d;
  logic [WIDTH-1:0]      out_q, out_d;
  logic [PRESC_BITS-1:0] prescale_q, prescale_d;
  logic [PRESC_BITS-1:0] presc_cnt_q, presc_cnt_d;
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0]   duty_q [WIDTH];
  logic [PWM_BITS-1:0]   duty_d [WIDTH];
  logic                  unused_wdata;

  assign wr_en        = chipselect && !write_n;
  assign tick         = (presc_cnt_q == '0);
  assign out_port     = out_q;
  // Upper write data bits are deliberately ignored by every register.
  assign unused_wdata = ^writedata;

  // Control register updates: DATA (direct, set, clear), MODE, PRESCALE.
  always_comb begin
    data_d     = data_q;
    mode_d     = mode_q;
    prescale_d = prescale_q;
    if (wr_en) begin
      case (address)
        c_addr_data:     data_d     = writedata[WIDTH-1:0];
        c_addr_outset:   data_d     = data_q | writedata[WIDTH-1:0];
        c_addr_outclear: data_d     = data_q & ~writedata[WIDTH-1:0];
        c_addr_mode:     mode_d     = writedata[WIDTH-1:0];
        c_addr_prescale: prescale_d = writedata[PRESC_BITS-1:0];
        default:         ;
      endcase
    end
  end

  // Duty registers live at consecutive addresses starting at 8.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      duty_d[i] = duty_q[i];
      if (wr_en && (address == c_addr_duty0 + 4'(i))) begin
        duty_d[i] = writedata[PWM_BITS-1:0];
      end
    end
  end

  // Prescaler countdown with reload on tick; a PRESCALE write restarts the interval.
  always_comb begin
    if (wr_en && (address == c_addr_prescale)) begin
      presc_cnt_d = writedata[PRESC_BITS-1:0];
    end else if (tick) begin
      presc_cnt_d = prescale_q;
    end else begin
      presc_cnt_d = presc_cnt_q - PRESC_BITS'(1);
    end
    pwm_cnt_d = tick ? (pwm_cnt_q + PWM_BITS'(1)) : pwm_cnt_q;
  end

  // Per-channel output select: static DATA, or DATA gated by the PWM compare.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      assign out_d[i] = mode_q[i] ? (data_q[i] && (pwm_cnt_q < duty_q[i])) : data_q[i];
    end
  endgenerate

  // State registers; reset clears the LED drive without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q      <= '0;
      mode_q      <= '0;
      prescale_q  <= PRESC_BITS'(PRESC_RESET);
      presc_cnt_q <= '0;
      pwm_cnt_q   <= '0;
      out_q       <= '0;
      for (int i = 0; i < WIDTH; i++) duty_q[i] <= '0;
    end else begin
      data_q      <= data_d;
      mode_q      <= mode_d;
      prescale_q  <= prescale_d;
      presc_cnt_q <= presc_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      out_q       <= out_d;
      for (int i = 0; i < WIDTH; i++) duty_q[i] <= duty_d[i];
    end
  end

  // Combinational read decode; write-only and unmapped addresses read 0.
  always_comb begin
    readdata = '0;
    case (address)
      c_addr_data:     readdata[WIDTH-1:0]      = data_q;
      c_addr_mode:     readdata[WIDTH-1:0]      = mode_q;
      c_addr_prescale: readdata[PRESC_BITS-1:0] = prescale_q;
      c_addr_pwmcnt:   readdata[PWM_BITS-1:0]   = pwm_cnt_q;
      default: begin
        for (int i = 0; i < WIDTH; i++) begin
          if (address == c_addr_duty0 + 4'(i)) readdata[PWM_BITS-1:0] = duty_q[i];
        end
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_nios_led_pwm_pio.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios_led_pwm_pio
// Purpose  : Self-checking bench for nios_led_pwm_pio: directed scenarios plus
//            randomized bus traffic against a cycle-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nios_led_pwm_pio;

  localparam int W    = 4;
  localparam int PB   = 8;
  localparam int PRB  = 16;
  localparam int PRST = 0;

  logic          clk;
  logic          reset;
  logic [3:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  out_port;

  int n_checks = 0;
  int n_errs   = 0;

  nios_led_pwm_pio #(
    .WIDTH(W), .PWM_BITS(PB), .PRESC_BITS(PRB), .PRESC_RESET(PRST)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit [W-1:0] m_data;
  bit [W-1:0] m_mode;
  bit [W-1:0] m_out;
  int         m_duty [W];
  int         m_presc_val = PRST;
  int         m_until_tick;   // cycles remaining before the next tick
  int         m_pwm;

  function automatic logic [31:0] m_read(input logic [3:0] a);
    logic [31:0] r;
    r = 0;
    if (a == 0) r = m_data;
    else if (a == 3) r = m_mode;
    else if (a == 4) r = m_presc_val;
    else if (a == 5) r = m_pwm;
    else if (a >= 8 && int'(a) < 8 + W) r = m_duty[a - 8];
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin : b_model
    int  old_presc;
    bit  tk;
    bit  we;
    if (reset) begin
      m_data = 0; m_mode = 0; m_out = 0;
      for (int i = 0; i < W; i++) m_duty[i] = 0;
      m_presc_val = PRST; m_until_tick = 0; m_pwm = 0;
    end else begin
      for (int i = 0; i < W; i++)
        m_out[i] = m_mode[i] ? (m_data[i] && (m_pwm < m_duty[i])) : m_data[i];
      tk        = (m_until_tick == 0);
      old_presc = m_presc_val;
      we        = chipselect && !write_n;
      if (tk) begin
        m_until_tick = old_presc;
        m_pwm        = (m_pwm + 1) % (1 << PB);
      end else begin
        m_until_tick = m_until_tick - 1;
      end
      if (we) begin
        case (address)
          4'd0: m_data = writedata[W-1:0];
          4'd1: m_data = m_data | writedata[W-1:0];
          4'd2: m_data = m_data & ~writedata[W-1:0];
          4'd3: m_mode = writedata[W-1:0];
          4'd4: begin
            m_presc_val  = writedata[PRB-1:0];
            m_until_tick = writedata[PRB-1:0];
          end
          default: if (address >= 8 && int'(address) < 8 + W) m_duty[address - 8] = writedata[PB-1:0];
        endcase
      end
    end
  end

  // Continuous comparison of outputs against the model, away from the active edge.
  always @(negedge clk) begin
    check("out_port", {{(32-W){1'b0}}, out_port}, {{(32-W){1'b0}}, m_out});
    check("readdata", readdata, m_read(address));
  end

  // ---------------- bus helpers ----------------
  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk); #2;
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk); #2;
    address = a;
    #1 check(tag, readdata, exp);
  endtask

  task automatic count_ch0(input int cycles, output int hi);
    hi = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk); #1;
      if (out_port[0]) hi++;
    end
  endtask

  int  hi;
  bit  found;

  initial begin
    reset = 1'b1; address = 4'd5; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    repeat (3) @(posedge clk);

    // Reset state: all readable registers and the outputs are zero.
    for (int a = 0; a < 16; a++) begin
      address = 4'(a);
      #1 check("reset_read", readdata, 32'h0);
    end
    check("reset_out", {28'h0, out_port}, 32'h0);
    address = 4'd5;

    // Ten cycles after release the PWM counter has advanced ten times.
    @(negedge clk); #2 reset = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); #1 check("pwmcnt_10", readdata, 32'd10);

    // Static DATA, then set and clear through the atomic registers.
    bus_wr(4'd0, 32'hA);
    @(posedge clk); @(negedge clk); #1 check("data_out", {28'h0, out_port}, 32'hA);
    bus_rd(4'd0, 32'hA, "data_rd");
    bus_wr(4'd1, 32'h1);
    bus_rd(4'd0, 32'hB, "outset_rd");
    @(negedge clk); #1 check("outset_out", {28'h0, out_port}, 32'hB);
    bus_wr(4'd2, 32'h2);
    bus_rd(4'd0, 32'h9, "outclear_rd");
    bus_rd(4'd1, 32'h0, "outset_reads0");
    bus_rd(4'd2, 32'h0, "outclear_reads0");

    // PWM at full rate, duty 64 of 256.
    bus_wr(4'd4, 32'd0);
    bus_wr(4'd3, 32'h1);
    bus_wr(4'd0, 32'h1);
    bus_wr(4'd8, 32'd64);
    repeat (3) @(negedge clk);
    count_ch0(256, hi);
    check("pwm_duty64", hi, 32'd64);
    check("static_others", {28'h0, out_port & 4'hE}, 32'h0);

    // Prescaled PWM: duty 1 is one count, i.e. 4 cycles of each 1024.
    bus_wr(4'd4, 32'd3);
    bus_wr(4'd8, 32'd1);
    repeat (3) @(negedge clk);
    count_ch0(1024, hi);
    check("pwm_presc3_duty1", hi, 32'd4);
    bus_wr(4'd8, 32'd0);
    repeat (3) @(negedge clk);
    count_ch0(1024, hi);
    check("pwm_duty0", hi, 32'd0);

    // Reset while ch0 is high mid-period.
    bus_wr(4'd8, 32'd64);
    found = 1'b0;
    for (int k = 0; k < 3000 && !found; k++) begin
      @(negedge clk); #1;
      if (out_port[0]) found = 1'b1;
    end
    check("wait_ch0_high", {31'h0, found}, 32'h1);
    @(posedge clk); #3 reset = 1'b1;
    #1 check("async_reset_out", {28'h0, out_port}, 32'h0);
    for (int a = 0; a < 16; a++) begin
      address = 4'(a);
      #0.1 check("reset_regs", readdata, (a == 4) ? 32'(PRST) : 32'h0);
    end
    @(negedge clk); #2 reset = 1'b0;

    // Unmapped addresses and upper write-data bits are ignored.
    bus_wr(4'd0, 32'hFFFF_FFF5);
    bus_rd(4'd0, 32'h5, "data_upper_ignored");
    bus_wr(4'd6, 32'hFFFF_FFFF);
    bus_wr(4'd7, 32'hFFFF_FFFF);
    bus_wr(4'd12, 32'hFFFF_FFFF);
    bus_rd(4'd6, 32'h0, "addr6_reads0");
    bus_rd(4'd7, 32'h0, "addr7_reads0");
    bus_rd(4'd12, 32'h0, "addr12_reads0");
    bus_rd(4'd0, 32'h5, "data_unchanged");
    bus_rd(4'd3, 32'h0, "mode_unchanged");
    bus_rd(4'd4, 32'h0, "presc_unchanged");
    bus_rd(4'd11, 32'h0, "duty3_unchanged");

    // Randomized traffic; the model comparison runs every cycle.
    for (int n = 0; n < 1500; n++) begin
      logic [3:0]  a;
      logic [31:0] d;
      a = 4'($urandom_range(0, 15));
      d = $urandom;
      if (a == 4'd4) d = $urandom_range(0, 5);
      @(negedge clk); #2;
      address    = a;
      writedata  = d;
      chipselect = 1'($urandom_range(0, 1));
      write_n    = 1'($urandom_range(0, 2) == 0);
    end
    @(negedge clk); #2 chipselect = 1'b0; write_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
